// File: rtl/uart_pkg.sv
// Shared UART types: parity selection, transmitter FSM states and line levels.
package uart_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE,
        PARITY_EVEN,
        PARITY_ODD
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam logic StartBit = 1'b0;
    localparam logic StopBit  = 1'b1;

endpackage

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start, DataBits LSB-first, optional parity, StopBits stop bits.
// Paced by an external sample_trigger; valid/ready byte handshake, one done pulse per frame.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int      DataBits      = 8,
    parameter int      SamplesPerBit = 16,
    parameter parity_e Parity        = PARITY_NONE,
    parameter int      StopBits      = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_trigger,
    input  logic [DataBits-1:0] data,
    input  logic                valid,
    output logic                ready,
    output logic                serial_data,
    output logic                busy,
    output logic                done
);

    if (DataBits < 5 || DataBits > 9) begin : g_bad_databits
        $error("uart_tx_frame: DataBits must be in 5..9");
    end
    if (SamplesPerBit < 2 || SamplesPerBit > 256) begin : g_bad_spb
        $error("uart_tx_frame: SamplesPerBit must be in 2..256");
    end
    if (StopBits < 1 || StopBits > 2) begin : g_bad_stop
        $error("uart_tx_frame: StopBits must be 1 or 2");
    end

    localparam int SCW = $clog2(SamplesPerBit);
    localparam int BCW = $clog2(DataBits + 1);
    localparam logic [SCW-1:0] SampleLast = SCW'(SamplesPerBit - 1);
    localparam logic [BCW-1:0] DataLast   = BCW'(DataBits - 1);
    localparam logic [BCW-1:0] StopLast   = BCW'(StopBits - 1);

    tx_state_e           r_state, w_state_nxt;
    logic [SCW-1:0]      r_sample_cnt, w_sample_nxt;
    logic [BCW-1:0]      r_bit_cnt, w_bit_nxt;
    logic [DataBits-1:0] r_shift, w_shift_nxt;
    logic                r_parity, w_parity_nxt;
    logic                r_serial, w_serial_nxt;
    logic                r_done, w_done_nxt;
    logic                r_ready, r_busy;
    logic                w_bit_val;
    logic                w_bit_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_sample_cnt <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_parity     <= 1'b0;
            r_serial     <= StopBit;
            r_done       <= 1'b0;
            r_ready      <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sample_cnt <= w_sample_nxt;
            r_bit_cnt    <= w_bit_nxt;
            r_shift      <= w_shift_nxt;
            r_parity     <= w_parity_nxt;
            r_serial     <= w_serial_nxt;
            r_done       <= w_done_nxt;
            r_ready      <= (w_state_nxt == IDLE);
            r_busy       <= (w_state_nxt != IDLE);
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_sample_nxt = r_sample_cnt;
        w_bit_nxt    = r_bit_cnt;
        w_shift_nxt  = r_shift;
        w_parity_nxt = r_parity;
        w_serial_nxt = r_serial;
        w_done_nxt   = 1'b0;
        w_bit_val    = StopBit;
        w_bit_end    = sample_trigger && (r_sample_cnt == SampleLast);

        unique case (r_state)
            IDLE: begin
                w_serial_nxt = StopBit;
                if (valid && r_ready) begin
                    w_state_nxt  = START;
                    w_shift_nxt  = data;
                    w_parity_nxt = (^data) ^ (Parity == PARITY_ODD);
                    w_sample_nxt = '0;
                    w_bit_nxt    = '0;
                end
            end
            START: begin
                w_bit_val = StartBit;
                if (w_bit_end) w_state_nxt = DATA;
            end
            DATA: begin
                w_bit_val = r_shift[0];
                if (w_bit_end) begin
                    w_shift_nxt = r_shift >> 1;
                    if (r_bit_cnt == DataLast) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = (Parity != PARITY_NONE) ? PARITY : STOP;
                    end else begin
                        w_bit_nxt = r_bit_cnt + 1'b1;
                    end
                end
            end
            PARITY: begin
                w_bit_val = r_parity;
                if (w_bit_end) w_state_nxt = STOP;
            end
            STOP: begin
                // bit_cnt is reused to count stop bits
                if (w_bit_end) begin
                    if (r_bit_cnt == StopLast) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_bit_nxt = r_bit_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // The line changes on the first trigger of each bit period
        if (r_state != IDLE && sample_trigger) begin
            if (r_sample_cnt == '0) w_serial_nxt = w_bit_val;
            w_sample_nxt = w_bit_end ? '0 : r_sample_cnt + 1'b1;
        end
    end

    assign ready       = r_ready;
    assign busy        = r_busy;
    assign serial_data = r_serial;
    assign done        = r_done;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Randomized bench for uart_tx_frame: three configurations checked every cycle against a
// trigger-count model of the expected line waveform.
module tb_uart_tx_frame;
    import uart_pkg::*;

    localparam int NDUT = 3;
    localparam int C_DB  [NDUT] = '{8, 7, 8};
    localparam int C_SPB [NDUT] = '{16, 8, 4};
    localparam int C_PAR [NDUT] = '{0, 1, 2};   // 0 none, 1 even, 2 odd
    localparam int C_SB  [NDUT] = '{1, 1, 2};

    logic            clk;
    logic            rst;
    logic            trig;
    logic            v;
    logic [7:0]      data_q;
    logic [NDUT-1:0] vld, ser, rdy, bsy, dn;

    int act;
    int gap, per_lo, per_hi;
    logic t_app;
    int n_chk, n_bad, n_dn;

    // reference model state
    bit   m_bits [$];
    bit   m_busy, m_ready, m_line, m_done;
    int   m_cnt;

    assign vld = {v && act == 2, v && act == 1, v && act == 0};

    uart_tx_frame #(.DataBits(8), .SamplesPerBit(16), .Parity(PARITY_NONE), .StopBits(1)) u0 (
        .clk(clk), .rst(rst), .sample_trigger(trig), .data(data_q[7:0]), .valid(vld[0]),
        .ready(rdy[0]), .serial_data(ser[0]), .busy(bsy[0]), .done(dn[0]));
    uart_tx_frame #(.DataBits(7), .SamplesPerBit(8), .Parity(PARITY_EVEN), .StopBits(1)) u1 (
        .clk(clk), .rst(rst), .sample_trigger(trig), .data(data_q[6:0]), .valid(vld[1]),
        .ready(rdy[1]), .serial_data(ser[1]), .busy(bsy[1]), .done(dn[1]));
    uart_tx_frame #(.DataBits(8), .SamplesPerBit(4), .Parity(PARITY_ODD), .StopBits(2)) u2 (
        .clk(clk), .rst(rst), .sample_trigger(trig), .data(data_q[7:0]), .valid(vld[2]),
        .ready(rdy[2]), .serial_data(ser[2]), .busy(bsy[2]), .done(dn[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time=%0t limit reached", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: dut=%0d got=%0h exp=%0h t=%0t", tag, act, got, exp, $time);
        end
    endtask

    // Expected frame from the protocol rules
    function automatic void build(input logic [7:0] d);
        bit p;
        p = 1'b0;
        m_bits.delete();
        m_bits.push_back(1'b0);
        for (int i = 0; i < C_DB[act]; i++) begin
            m_bits.push_back(d[i]);
            p ^= d[i];
        end
        if (C_PAR[act] == 1) m_bits.push_back(p);
        else if (C_PAR[act] == 2) m_bits.push_back(!p);
        for (int i = 0; i < C_SB[act]; i++) m_bits.push_back(1'b1);
    endfunction

    function automatic void model_step();
        int spb;
        spb = C_SPB[act];
        m_done = 1'b0;
        if (rst) begin
            m_busy = 1'b0; m_ready = 1'b0; m_line = 1'b1; m_cnt = 0;
        end else if (!m_busy) begin
            m_line = 1'b1;
            if (m_ready && v) begin
                build(data_q);
                m_busy = 1'b1;
                m_cnt  = 0;
            end
            m_ready = !m_busy;
        end else if (t_app) begin
            if (m_cnt % spb == 0) m_line = m_bits[m_cnt / spb];
            m_cnt++;
            if (m_cnt == m_bits.size() * spb) begin
                m_busy = 1'b0; m_done = 1'b1; m_ready = 1'b1;
            end
        end
    endfunction

    task automatic tick(input bit force_trig);
        if (force_trig || gap == 0) begin
            trig = 1'b1;
            gap  = int'($urandom_range(per_hi, per_lo)) - 1;
        end else begin
            trig = 1'b0;
            gap--;
        end
        @(posedge clk);
        t_app = trig;
        model_step();
        #1;
        if (dn[act]) n_dn++;
        chk("serial", 32'(ser[act]), 32'(m_line));
        chk("ready",  32'(rdy[act]), 32'(m_ready));
        chk("busy",   32'(bsy[act]), 32'(m_busy));
        chk("done",   32'(dn[act]),  32'(m_done));
    endtask

    task automatic wait_ready();
        int guard;
        guard = 0;
        while (!m_ready && guard < 100) begin
            tick(1'b0);
            guard++;
        end
    endtask

    task automatic send(input logic [7:0] d, input bit coinc);
        int guard, ntr, nbits, lim;
        nbits = 1 + C_DB[act] + int'(C_PAR[act] != 0) + C_SB[act];
        lim   = nbits * C_SPB[act] * (per_hi + 1) + 50;
        wait_ready();
        v = 1'b1;
        data_q = d;
        tick(coinc);
        v = 1'b0;
        ntr = 0;
        guard = 0;
        while (dn[act] !== 1'b1 && guard < lim) begin
            tick(1'b0);
            guard++;
            if (t_app) ntr++;
        end
        chk("frame_trigs", 32'(ntr), 32'(nbits * C_SPB[act]));
        tick(1'b0);
    endtask

    initial begin
        int d0, guard;
        n_chk = 0; n_bad = 0; n_dn = 0;
        act = 0; gap = 0; per_lo = 4; per_hi = 4;
        rst = 1'b1; v = 1'b0; data_q = '0; trig = 1'b0; t_app = 1'b0;
        m_busy = 1'b0; m_ready = 1'b0; m_line = 1'b1; m_done = 1'b0; m_cnt = 0;

        // reset state, then ready on the first edge after release
        repeat (3) tick(1'b0);
        rst = 1'b0;
        tick(1'b0);
        chk("ready_after_rst", 32'(rdy[0]), 32'd1);

        // directed frames from the test plan, trigger every 4 clocks
        d0 = n_dn;
        send(8'hA5, 1'b0);
        chk("a5_frames", 32'(n_dn - d0), 32'd1);
        act = 1; send(8'h35, 1'b0);
        act = 2; send(8'hFF, 1'b0);

        // accept coinciding with a trigger
        act = 2; send(8'h3C, 1'b1);
        act = 0; send(8'h81, 1'b1);

        // randomized data and trigger spacing on every configuration
        per_lo = 2; per_hi = 6;
        for (int a = 0; a < NDUT; a++) begin
            act = a;
            for (int k = 0; k < 3; k++) send(8'($urandom), ($urandom_range(3, 0) == 0));
        end

        // back-to-back with valid held, then valid pulses while busy
        act = 0; per_lo = 4; per_hi = 4;
        wait_ready();
        d0 = n_dn;
        v = 1'b1; data_q = 8'h00;
        tick(1'b0);
        data_q = 8'hFF;
        guard = 0;
        while (!m_done && guard < 2000) begin tick(1'b0); guard++; end
        tick(1'b0);
        chk("b2b_accept", 32'(bsy[0]), 32'd1);
        guard = 0;
        while (m_busy && guard < 2000) begin
            v = (m_cnt < (m_bits.size() - 2) * C_SPB[0]) ? 1'($urandom_range(1, 0)) : 1'b0;
            data_q = 8'($urandom);
            tick(1'b0);
            guard++;
        end
        v = 1'b0;
        repeat (20) tick(1'b0);
        chk("b2b_frames", 32'(n_dn - d0), 32'd2);

        // reset while data bit 3 is on the line
        act = 0;
        wait_ready();
        d0 = n_dn;
        v = 1'b1; data_q = 8'($urandom);
        tick(1'b0);
        v = 1'b0;
        guard = 0;
        while (m_cnt <= 4 * C_SPB[0] && guard < 2000) begin tick(1'b0); guard++; end
        rst = 1'b1;
        tick(1'b0);
        chk("abort_serial", 32'(ser[0]), 32'd1);
        chk("abort_busy",   32'(bsy[0]), 32'd0);
        rst = 1'b0;
        tick(1'b0);
        chk("abort_ready",  32'(rdy[0]), 32'd1);
        repeat (10) tick(1'b0);
        chk("abort_nodone", 32'(n_dn - d0), 32'd0);
        send(8'h5A, 1'b0);
        chk("fresh_frames", 32'(n_dn - d0), 32'd1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
